// File: rtl/sram_arbiter_pkg.sv
// Shared types and defaults for the two-client SRAM arbiter.
package sram_arb_pkg;

  localparam int NUM_CLIENTS = 2;
  localparam int AW_DEF      = 18;
  localparam int DW_DEF      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sram_arbiter_if.sv
// Client handshakes plus the sram_ctrl command/return port, bundled for the arbiter.
interface sram_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          c0_req;
  logic          c0_rw;
  logic [AW-1:0] c0_addr;
  logic [DW-1:0] c0_wdata;
  logic          c0_ack;
  logic [DW-1:0] c0_rdata;

  logic          c1_req;
  logic          c1_rw;
  logic [AW-1:0] c1_addr;
  logic [DW-1:0] c1_wdata;
  logic          c1_ack;
  logic [DW-1:0] c1_rdata;

  logic          ram_mem;
  logic          ram_rw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_ready;
  logic [DW-1:0] ram_rdata;

  logic          busy;
  logic          gnt_id;

  // Arbiter side.
  modport slave (
    input  c0_req, c0_rw, c0_addr, c0_wdata,
    output c0_ack, c0_rdata,
    input  c1_req, c1_rw, c1_addr, c1_wdata,
    output c1_ack, c1_rdata,
    output ram_mem, ram_rw, ram_addr, ram_wdata,
    input  ram_ready, ram_rdata,
    output busy, gnt_id
  );

  // Clients plus sram_ctrl side.
  modport master (
    output c0_req, c0_rw, c0_addr, c0_wdata,
    input  c0_ack, c0_rdata,
    output c1_req, c1_rw, c1_addr, c1_wdata,
    input  c1_ack, c1_rdata,
    input  ram_mem, ram_rw, ram_addr, ram_wdata,
    output ram_ready, ram_rdata,
    input  busy, gnt_id
  );

endinterface

// File: rtl/sram_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: on a conflict the client not served last wins.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       valid_o,
  output logic       winner_o
);

  assign valid_o = |req_i;

  always_comb begin
    winner_o = 1'b0;
    case (req_i)
      2'b01:   winner_o = 1'b0;
      2'b10:   winner_o = 1'b1;
      2'b11:   winner_o = ~last_grant_i;
      default: winner_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-client round-robin sequencer in front of sram_ctrl: latch one command,
// strobe mem once, wait for ready, return read data and ack to the winner only.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for a request while sram_ctrl reports ready
// ST_ISSUE | ram_mem high for this single cycle with the latched command
// ST_WAIT  | waiting for sram_ctrl ready; read data captured on exit
// ST_DONE  | one-cycle ack to the granted client, round-robin pointer updated
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  sram_arbiter_if.slave  bus
);

  state_e                 state_q;
  logic                   last_grant_q;
  logic                   gnt_id_q;
  logic                   busy_q;
  logic                   ram_mem_q;
  logic                   ram_rw_q;
  logic [AW-1:0]          ram_addr_q;
  logic [DW-1:0]          ram_wdata_q;
  logic [NUM_CLIENTS-1:0] ack_q;
  logic [DW-1:0]          c0_rdata_q;
  logic [DW-1:0]          c1_rdata_q;

  logic                   pick_valid;
  logic                   pick_winner;
  logic                   cmd_rw_d;
  logic [AW-1:0]          cmd_addr_d;
  logic [DW-1:0]          cmd_wdata_d;

  rr_pick2 u_pick (
    .req_i        ({bus.c1_req, bus.c0_req}),
    .last_grant_i (last_grant_q),
    .valid_o      (pick_valid),
    .winner_o     (pick_winner)
  );

  always_comb begin
    cmd_rw_d    = bus.c0_rw;
    cmd_addr_d  = bus.c0_addr;
    cmd_wdata_d = bus.c0_wdata;
    if (pick_winner) begin
      cmd_rw_d    = bus.c1_rw;
      cmd_addr_d  = bus.c1_addr;
      cmd_wdata_d = bus.c1_wdata;
    end
  end

  // The ram_* command registers double as the latched command, so they stay
  // stable from ISSUE through DONE regardless of what the client does.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      gnt_id_q     <= 1'b0;
      busy_q       <= 1'b0;
      ram_mem_q    <= 1'b0;
      ram_rw_q     <= 1'b1;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ack_q        <= '0;
      c0_rdata_q   <= '0;
      c1_rdata_q   <= '0;
    end else begin
      ram_mem_q <= 1'b0;
      ack_q     <= '0;
      case (state_q)
        ST_IDLE: begin
          if (bus.ram_ready && pick_valid) begin
            gnt_id_q    <= pick_winner;
            ram_rw_q    <= cmd_rw_d;
            ram_addr_q  <= cmd_addr_d;
            ram_wdata_q <= cmd_wdata_d;
            ram_mem_q   <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (bus.ram_ready) begin
            if (ram_rw_q) begin
              if (gnt_id_q) c1_rdata_q <= bus.ram_rdata;
              else          c0_rdata_q <= bus.ram_rdata;
            end
            ack_q[gnt_id_q] <= 1'b1;
            state_q         <= ST_DONE;
          end
        end
        ST_DONE: begin
          last_grant_q <= gnt_id_q;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ram_mem   = ram_mem_q;
  assign bus.ram_rw    = ram_rw_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.c0_ack    = ack_q[0];
  assign bus.c1_ack    = ack_q[1];
  assign bus.c0_rdata  = c0_rdata_q;
  assign bus.c1_rdata  = c1_rdata_q;
  assign bus.busy      = busy_q;
  assign bus.gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small sram_ctrl model (ready low 2 cycles per access).
module tb_sram_arbiter;

  localparam int AW   = 18;
  localparam int DW   = 16;
  localparam int BUSY = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if #(.AW(AW), .DW(DW)) bus_if ();

  sram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  // sram_ctrl model: accepts mem while ready, then holds ready low for BUSY cycles.
  logic          m_ready;
  int            m_cnt;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] sram [0:255];
  logic          hold_low = 1'b0;

  assign bus_if.ram_ready = m_ready & ~hold_low;
  assign bus_if.ram_rdata = m_rdata;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ready     <= 1'b1;
      m_cnt       <= 0;
      m_rdata     <= 16'hDEAD;
      sram[8'hFF] <= 16'hBEEF;
    end else if (bus_if.ram_mem && bus_if.ram_ready) begin
      m_ready <= 1'b0;
      m_cnt   <= BUSY - 1;
      if (bus_if.ram_rw) m_rdata <= sram[bus_if.ram_addr[7:0]];
      else               sram[bus_if.ram_addr[7:0]] <= bus_if.ram_wdata;
    end else if (!m_ready) begin
      if (m_cnt == 0) m_ready <= 1'b1;
      else            m_cnt   <= m_cnt - 1;
    end
  end

  int ack_log[$];
  int mem_pulses = 0;
  always @(posedge clk) begin
    if (bus_if.c0_ack) ack_log.push_back(0);
    if (bus_if.c1_ack) ack_log.push_back(1);
    if (bus_if.ram_mem) mem_pulses++;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int log_at(input int i);
    return (i < ack_log.size()) ? ack_log[i] : -1;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit cl, input bit rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (cl) begin
      bus_if.c1_req = 1'b1; bus_if.c1_rw = rw; bus_if.c1_addr = addr; bus_if.c1_wdata = wd;
    end else begin
      bus_if.c0_req = 1'b1; bus_if.c0_rw = rw; bus_if.c0_addr = addr; bus_if.c0_wdata = wd;
    end
  endtask

  // Single-client transfer; returns cycles from request to ack (0 on timeout).
  task automatic xfer(input bit cl, input bit rw, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, output int lat);
    drive(cl, rw, addr, wd);
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if ((cl && bus_if.c1_ack) || (!cl && bus_if.c0_ack)) begin
        lat = i;
        break;
      end
    end
    bus_if.c0_req = 1'b0;
    bus_if.c1_req = 1'b0;
  endtask

  // Both requests already raised; each drops on its own ack.
  task automatic run_both(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus_if.c0_ack) bus_if.c0_req = 1'b0;
      if (bus_if.c1_ack) bus_if.c1_req = 1'b0;
      if (!bus_if.c0_req && !bus_if.c1_req) begin
        done = 1'b1;
        break;
      end
    end
    bus_if.c0_req = 1'b0;
    bus_if.c1_req = 1'b0;
    step();
    check(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int p0;
    int seen;
    bit ok;

    bus_if.c0_req = 1'b0; bus_if.c0_rw = 1'b1; bus_if.c0_addr = '0; bus_if.c0_wdata = '0;
    bus_if.c1_req = 1'b0; bus_if.c1_rw = 1'b1; bus_if.c1_addr = '0; bus_if.c1_wdata = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_busy",      32'(bus_if.busy),      32'd0);
    check("rst_ram_mem",   32'(bus_if.ram_mem),   32'd0);
    check("rst_ram_rw",    32'(bus_if.ram_rw),    32'd1);
    check("rst_ram_addr",  32'(bus_if.ram_addr),  32'd0);
    check("rst_ram_wdata", 32'(bus_if.ram_wdata), 32'd0);
    check("rst_c0_ack",    32'(bus_if.c0_ack),    32'd0);
    check("rst_c1_ack",    32'(bus_if.c1_ack),    32'd0);
    check("rst_c0_rdata",  32'(bus_if.c0_rdata),  32'd0);
    check("rst_c1_rdata",  32'(bus_if.c1_rdata),  32'd0);
    check("rst_gnt_id",    32'(bus_if.gnt_id),    32'd0);

    reset_n = 1'b1;
    step();

    // Write from client 0, cycle by cycle.
    p0 = mem_pulses;
    drive(1'b0, 1'b0, 18'h00012, 16'h00A5);
    step();
    check("wr_issue_mem",   32'(bus_if.ram_mem),   32'd1);
    check("wr_issue_rw",    32'(bus_if.ram_rw),    32'd0);
    check("wr_issue_addr",  32'(bus_if.ram_addr),  32'h00012);
    check("wr_issue_wdata", 32'(bus_if.ram_wdata), 32'h00A5);
    check("wr_issue_gnt",   32'(bus_if.gnt_id),    32'd0);
    check("wr_issue_busy",  32'(bus_if.busy),      32'd1);
    step();
    check("wr_wait_mem",    32'(bus_if.ram_mem),   32'd0);
    check("wr_wait_ack",    32'(bus_if.c0_ack),    32'd0);
    step();
    step();
    check("wr_c4_ack",      32'(bus_if.c0_ack),    32'd0);
    step();
    check("wr_c5_c0_ack",   32'(bus_if.c0_ack),    32'd1);
    check("wr_c5_c1_ack",   32'(bus_if.c1_ack),    32'd0);
    check("wr_c5_busy",     32'(bus_if.busy),      32'd1);
    bus_if.c0_req = 1'b0;
    step();
    check("wr_end_ack",     32'(bus_if.c0_ack),    32'd0);
    check("wr_end_busy",    32'(bus_if.busy),      32'd0);
    check("wr_mem_pulses",  32'(mem_pulses - p0),  32'd1);
    check("wr_ack_count",   32'(ack_log.size()),   32'd1);
    check("wr_ack_who",     32'(log_at(0)),        32'd0);

    // Read from client 1 at the top address.
    xfer(1'b1, 1'b1, 18'h3FFFF, 16'h0000, lat);
    check("rd_c1_latency",  32'(lat),              32'd5);
    check("rd_c1_rdata",    32'(bus_if.c1_rdata),  32'hBEEF);
    check("rd_c0_rdata",    32'(bus_if.c0_rdata),  32'd0);
    check("rd_gnt_id",      32'(bus_if.gnt_id),    32'd1);
    step();
    check("rd_ack_who",     32'(log_at(1)),        32'd1);
    xfer(1'b0, 1'b0, 18'h00020, 16'h5A5A, lat);
    check("wr2_latency",    32'(lat),              32'd5);
    check("rd_c1_hold",     32'(bus_if.c1_rdata),  32'hBEEF);
    check("wr2_c0_rdata",   32'(bus_if.c0_rdata),  32'd0);
    step();

    // Simultaneous requests straight after reset.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    ack_log.delete();
    drive(1'b0, 1'b1, 18'h00012, 16'h0000);
    drive(1'b1, 1'b0, 18'h00030, 16'h7777);
    run_both("sim1_done");
    check("sim1_first",     32'(log_at(0)),        32'd0);
    check("sim1_second",    32'(log_at(1)),        32'd1);
    check("sim1_c0_rdata",  32'(bus_if.c0_rdata),  32'h00A5);
    drive(1'b0, 1'b1, 18'h00030, 16'h0000);
    drive(1'b1, 1'b1, 18'h00012, 16'h0000);
    run_both("sim2_done");
    check("sim2_first",     32'(log_at(2)),        32'd0);
    check("sim2_second",    32'(log_at(3)),        32'd1);
    check("sim2_c0_rdata",  32'(bus_if.c0_rdata),  32'h7777);
    check("sim2_c1_rdata",  32'(bus_if.c1_rdata),  32'h00A5);

    // Both clients hold requests across four transfers.
    ack_log.delete();
    p0 = mem_pulses;
    drive(1'b0, 1'b1, 18'h00020, 16'h0000);
    drive(1'b1, 1'b0, 18'h00040, 16'h1111);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      seen += int'(bus_if.c0_ack) + int'(bus_if.c1_ack);
      if (seen >= 4) break;
    end
    bus_if.c0_req = 1'b0;
    bus_if.c1_req = 1'b0;
    step();
    check("starve_count",   32'(ack_log.size()),   32'd4);
    check("starve_g0",      32'(log_at(0)),        32'd0);
    check("starve_g1",      32'(log_at(1)),        32'd1);
    check("starve_g2",      32'(log_at(2)),        32'd0);
    check("starve_g3",      32'(log_at(3)),        32'd1);
    check("starve_pulses",  32'(mem_pulses - p0),  32'd4);
    check("starve_c0_rd",   32'(bus_if.c0_rdata),  32'h5A5A);

    // Ready gating in IDLE.
    hold_low = 1'b1;
    p0 = mem_pulses;
    drive(1'b0, 1'b0, 18'h00055, 16'hCAFE);
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus_if.ram_mem !== 1'b0 || bus_if.busy !== 1'b0) ok = 1'b0;
    end
    check("gate_idle",      32'(ok),               32'd1);
    check("gate_pulses",    32'(mem_pulses - p0),  32'd0);
    hold_low = 1'b0;
    step();
    check("gate_issue_mem", 32'(bus_if.ram_mem),   32'd1);
    check("gate_issue_addr",32'(bus_if.ram_addr),  32'h00055);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus_if.c0_ack) begin
        seen = 1;
        break;
      end
    end
    bus_if.c0_req = 1'b0;
    check("gate_ack",       32'(seen),             32'd1);
    step();

    // Reset while waiting on sram_ctrl; last grant was client 0.
    ack_log.delete();
    drive(1'b0, 1'b1, 18'h00055, 16'h0000);
    step();
    check("rstw_issue_mem", 32'(bus_if.ram_mem),   32'd1);
    step();
    check("rstw_wait_busy", 32'(bus_if.busy),      32'd1);
    reset_n = 1'b0;
    bus_if.c0_req = 1'b0;
    #1;
    check("rstw_mem",       32'(bus_if.ram_mem),   32'd0);
    check("rstw_busy",      32'(bus_if.busy),      32'd0);
    check("rstw_c0_ack",    32'(bus_if.c0_ack),    32'd0);
    step();
    step();
    check("rstw_no_ack",    32'(ack_log.size()),   32'd0);
    reset_n = 1'b1;
    step();
    drive(1'b0, 1'b1, 18'h00055, 16'h0000);
    drive(1'b1, 1'b1, 18'h3FFFF, 16'h0000);
    run_both("rstw_both_done");
    check("rstw_first",     32'(log_at(0)),        32'd0);
    check("rstw_second",    32'(log_at(1)),        32'd1);
    check("rstw_c0_rdata",  32'(bus_if.c0_rdata),  32'hCAFE);
    check("rstw_c1_rdata",  32'(bus_if.c1_rdata),  32'hBEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
